// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch word/PC, applies flush/stall,
// and replaces repeated control words with bubbles while a branch resolves.
//
// Ports:
//   clk, rst_n (sync, active-low)
//   inst_data_i / inst_addr_i : fetched word and its PC
//   jump_flag_i / clear_i     : flush (taken redirect / pipeline flush)
//   resolve_i                 : branch resolved not-taken, leave WAIT
//   hold_i                    : stall, freezes every register
//   inst_o / inst_addr_o / valid_o : instruction handed to decode
//   wait_o, bubble_cnt_o, timeout_o : WAIT status, bubble count, sticky timeout
module if_id_reg #(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 16,
  parameter logic [4:0]  OP_BEQ   = 5'h10,
  parameter logic [4:0]  OP_BLE   = 5'h11,
  parameter logic [4:0]  OP_JAL   = 5'h12,
  parameter logic [4:0]  OP_JR    = 5'h13,
  parameter int          MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inst_data_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              jump_flag_i,
  input  logic              resolve_i,
  input  logic              clear_i,
  input  logic              hold_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              valid_o,
  output logic              wait_o,
  output logic [7:0]        bubble_cnt_o,
  output logic              timeout_o
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t              r_state;
  logic [7:0]          r_wait_cnt;
  logic [DATA_W-1:0]   r_inst;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_valid;
  logic [7:0]          r_bcnt;
  logic                r_tmo;

  state_t              w_state_nxt;
  logic [7:0]          w_wait_nxt;
  logic [DATA_W-1:0]   w_inst_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_valid_nxt;
  logic [7:0]          w_bcnt_nxt;
  logic                w_tmo_nxt;

  logic                w_flush;
  logic                w_is_ctrl;
  logic [4:0]          w_op;

  assign w_flush = clear_i | jump_flag_i;
  assign w_op    = inst_data_i[4:0];
  assign w_is_ctrl = (w_op == OP_BEQ) | (w_op == OP_BLE) |
                     (w_op == OP_JAL) | (w_op == OP_JR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_inst     <= '0;
      r_addr     <= '0;
      r_valid    <= 1'b0;
      r_bcnt     <= '0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_inst     <= w_inst_nxt;
      r_addr     <= w_addr_nxt;
      r_valid    <= w_valid_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_inst_nxt  = r_inst;
    w_addr_nxt  = r_addr;
    w_valid_nxt = r_valid;
    w_bcnt_nxt  = r_bcnt;
    w_tmo_nxt   = r_tmo;
    if (w_flush) begin
      w_inst_nxt  = '0;
      w_valid_nxt = 1'b0;
      w_state_nxt = S_RUN;
      w_wait_nxt  = '0;
    end else if (hold_i) begin
      w_state_nxt = r_state;
    end else if (r_state == S_RUN) begin
      if (inst_data_i == '0) begin
        w_inst_nxt  = '0;
        w_valid_nxt = 1'b0;
      end else begin
        w_inst_nxt  = inst_data_i;
        w_addr_nxt  = inst_addr_i;
        w_valid_nxt = 1'b1;
        if (w_is_ctrl) begin
          w_state_nxt = S_WAIT;
          w_wait_nxt  = '0;
        end
      end
    end else begin
      // Repeated control word is dropped; PC of the issued one stays.
      w_inst_nxt  = '0;
      w_valid_nxt = 1'b0;
      if (r_bcnt != 8'hFF) begin
        w_bcnt_nxt = r_bcnt + 8'd1;
      end
      if (resolve_i) begin
        w_state_nxt = S_RUN;
        w_wait_nxt  = '0;
      end else if (r_wait_cnt == WAIT_LAST) begin
        w_tmo_nxt   = 1'b1;
        w_state_nxt = S_RUN;
        w_wait_nxt  = '0;
      end else begin
        w_wait_nxt = r_wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    inst_o       = r_inst;
    inst_addr_o  = r_addr;
    valid_o      = r_valid;
    wait_o       = (r_state == S_WAIT);
    bubble_cnt_o = r_bcnt;
    timeout_o    = r_tmo;
  end

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: directed scenarios then random traffic,
// expected outputs from a behavioural model pushed into a queue.
module tb_if_id_reg;

  localparam int MAXW = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] inst_data_i;
  logic [15:0] inst_addr_i;
  logic        jump_flag_i;
  logic        resolve_i;
  logic        clear_i;
  logic        hold_i;
  logic [15:0] inst_o;
  logic [15:0] inst_addr_o;
  logic        valid_o;
  logic        wait_o;
  logic [7:0]  bubble_cnt_o;
  logic        timeout_o;

  if_id_reg #(
    .ADDR_W(16), .DATA_W(16),
    .OP_BEQ(5'h10), .OP_BLE(5'h11),
    .OP_JAL(5'h12), .OP_JR(5'h13),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_data_i(inst_data_i),
    .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i),
    .resolve_i(resolve_i),
    .clear_i(clear_i),
    .hold_i(hold_i),
    .inst_o(inst_o),
    .inst_addr_o(inst_addr_o),
    .valid_o(valid_o),
    .wait_o(wait_o),
    .bubble_cnt_o(bubble_cnt_o),
    .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] addr;
    logic        valid;
    logic        wt;
    logic [7:0]  bcnt;
    logic        tmo;
  } obs_t;

  obs_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // model state
  obs_t m;
  bit   m_waiting;
  int   m_waited;
  int   m_bubbles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_ctrl(logic [15:0] w);
    int op;
    op = int'(w[4:0]);
    return (op >= 16 && op <= 19);
  endfunction

  task automatic model_reset();
    m = '0;
    m_waiting = 0;
    m_waited = 0;
    m_bubbles = 0;
  endtask

  task automatic model_step(logic r, logic [15:0] d, logic [15:0] a,
                            logic j, logic rs, logic c, logic h);
    if (!r) begin
      model_reset();
    end else if (c || j) begin
      m.inst = 0; m.valid = 0;
      m_waiting = 0; m_waited = 0;
    end else if (h) begin
    end else if (!m_waiting) begin
      if (d == 0) begin
        m.inst = 0; m.valid = 0;
      end else begin
        m.inst = d; m.addr = a; m.valid = 1;
        if (is_ctrl(d)) begin
          m_waiting = 1; m_waited = 0;
        end
      end
    end else begin
      m.inst = 0; m.valid = 0;
      m_bubbles++;
      m_waited++;
      if (rs) m_waiting = 0;
      else if (m_waited == MAXW) begin
        m_waiting = 0; m.tmo = 1;
      end
    end
    m.wt   = m_waiting;
    m.bcnt = (m_bubbles > 255) ? 8'd255 : 8'(m_bubbles);
  endtask

  task automatic cyc(logic r, logic [15:0] d, logic [15:0] a,
                     logic j, logic rs, logic c, logic h);
    @(negedge clk);
    rst_n = r; inst_data_i = d; inst_addr_i = a;
    jump_flag_i = j; resolve_i = rs; clear_i = c; hold_i = h;
    model_step(r, d, a, j, rs, c, h);
    q.push_back(m);
  endtask

  task automatic run(logic [15:0] d, logic [15:0] a);
    cyc(1, d, a, 0, 0, 0, 0);
  endtask

  // monitor
  initial begin
    obs_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = '{inst_o, inst_addr_o, valid_o, wait_o,
                bubble_cnt_o, timeout_o};
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL obs t=%0t got inst=%h addr=%h v=%b w=%b bc=%0d to=%b exp inst=%h addr=%h v=%b w=%b bc=%0d to=%b",
                   $time, act.inst, act.addr, act.valid, act.wt,
                   act.bcnt, act.tmo, e.inst, e.addr, e.valid, e.wt,
                   e.bcnt, e.tmo);
        end
      end
    end
  end

  initial begin
    rst_n = 0; inst_data_i = 0; inst_addr_i = 0;
    jump_flag_i = 0; resolve_i = 0; clear_i = 0; hold_i = 0;
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 16'h1234, 16'h7, 0, 0, 0, 0);
    // straight line
    run(16'h1234, 0);
    run(16'h5678, 1);
    run(16'h0000, 2);
    // BEQ held 3 cycles, resolve on the third
    run(16'h0010, 2);
    run(16'h0010, 2);
    run(16'h0010, 2);
    cyc(1, 16'h0010, 2, 0, 1, 0, 0);
    run(16'h1234, 3);
    // JAL, wait, jump to 0x0042
    run(16'h0012, 4);
    run(16'h0012, 4);
    cyc(1, 16'h0012, 4, 1, 0, 0, 0);
    run(16'h0042, 9);
    // hold in RUN
    run(16'h1234, 10);
    cyc(1, 16'h5555, 11, 0, 0, 0, 1);
    cyc(1, 16'h5555, 11, 0, 0, 0, 1);
    // hold in WAIT: resolve is lost while held
    run(16'h0012, 11);
    run(16'h0012, 11);
    cyc(1, 16'h0012, 11, 0, 1, 0, 1);
    cyc(1, 16'h0012, 11, 0, 1, 0, 1);
    cyc(1, 16'h0012, 11, 0, 1, 0, 0);
    // JR timeout
    run(16'h0013, 12);
    repeat (MAXW + 1) run(16'h0013, 12);
    run(16'h2222, 13);
    cyc(0, 0, 0, 0, 0, 0, 0);
    run(16'h5678, 13);
    // clear beats hold
    cyc(1, 16'h1111, 14, 0, 0, 1, 1);
    // reset mid-WAIT
    run(16'h0011, 15);
    run(16'h0011, 15);
    run(16'h0011, 15);
    cyc(0, 16'h0011, 15, 0, 0, 0, 0);
    run(16'h0003, 16);
    // resolve with jump: flush wins
    run(16'h0010, 17);
    cyc(1, 16'h0010, 17, 1, 1, 0, 0);
    // bubble counter saturation
    for (int i = 0; i < 40; i++) begin
      run(16'h0013, 16'(20 + i));
      repeat (MAXW) run(16'h0013, 16'(20 + i));
    end
    run(16'h0013, 99);
    run(16'h0013, 99);
    // random traffic
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      int k;
      k = $urandom_range(0, 9);
      if (k < 3) d = {11'($urandom), 5'(16 + $urandom_range(0, 3))};
      else if (k == 3) d = 0;
      else d = 16'($urandom);
      cyc(($urandom_range(0, 199) != 0), d, 16'($urandom),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0));
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
